// File: rtl/tick_updown_counter_pkg.sv
// Shared types and constants for the tick up/down counter core.
package tick_counter_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/tick_updown_counter_prescaler.sv
// Reusable tick prescaler: one-cycle o_tick every PRESCALE enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_sclr,
  output logic o_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (i_sclr) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (i_en) begin
      if (cnt == LAST) begin
        cnt    <= '0;
        o_tick <= 1'b1;
      end else begin
        cnt    <= cnt + PW'(1);
        o_tick <= 1'b0;
      end
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_updown_counter.sv
// Modulo-MOD up/down event counter with tick prescaler and run/stop/clear FSM.
// Optional synchronous load port enabled by defining TICK_COUNTER_LOAD_EN.
module tick_updown_counter
  import tick_counter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int MOD     = 10_000,
  localparam int W      = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_mode,
  input  logic         i_run_stop,
  input  logic         i_clear,
`ifdef TICK_COUNTER_LOAD_EN
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
`endif
  output logic [W-1:0] o_count,
  output logic         o_running,
  output logic         o_tick,
  output logic         o_tc
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam logic [W-1:0] CNT_MAX = W'(MOD - 1);

  state_t state, state_nxt;
  logic run_q;
  logic tick_take;
  logic [W-1:0] count_step;
  logic tc_step;

  assign run_q     = (state == ST_RUN);
  assign o_running = run_q;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_en   (run_q),
    .i_sclr (~run_q),
    .o_tick (o_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_STOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:  if (i_run_stop) state_nxt = ST_RUN;
      ST_RUN:   if (i_run_stop) state_nxt = ST_STOP;
      ST_CLEAR: state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
    if (i_clear) state_nxt = ST_CLEAR;
  end

  // A tick only counts if the FSM stays in RUN across this edge.
  assign tick_take = o_tick & run_q & (state_nxt == ST_RUN);

  always_comb begin
    count_step = o_count;
    tc_step    = 1'b0;
    if (i_mode == MODE_UP) begin
      if (o_count == CNT_MAX) begin
        count_step = '0;
        tc_step    = 1'b1;
      end else begin
        count_step = o_count + W'(1);
      end
    end else begin
      if (o_count == '0) begin
        count_step = CNT_MAX;
        tc_step    = 1'b1;
      end else begin
        count_step = o_count - W'(1);
      end
    end
  end

`ifdef TICK_COUNTER_LOAD_EN
  logic [W-1:0] load_clamped;
  assign load_clamped = (i_load_val > CNT_MAX) ? CNT_MAX : i_load_val;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_count <= '0;
      o_tc    <= 1'b0;
    end else if (i_clear) begin
      o_count <= '0;
      o_tc    <= 1'b0;
`ifdef TICK_COUNTER_LOAD_EN
    end else if (i_load) begin
      o_count <= load_clamped;
      o_tc    <= 1'b0;
`endif
    end else if (tick_take) begin
      o_count <= count_step;
      o_tc    <= tc_step;
    end else begin
      o_tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_updown_counter.sv
// Self-checking bench for tick_updown_counter: directed scenarios plus random traffic vs. a behavioural model.
module tb_tick_updown_counter;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int MOD     = 10;
  localparam int P       = CLK_HZ / TICK_HZ;
  localparam int W       = $clog2(MOD);

  logic         clk = 1'b0;
  logic         reset;
  logic         i_mode, i_run_stop, i_clear;
  logic [W-1:0] o_count;
  logic         o_running, o_tick, o_tc;
`ifdef TICK_COUNTER_LOAD_EN
  logic         i_load;
  logic [W-1:0] i_load_val;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  tick_updown_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MOD(MOD)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_mode     (i_mode),
    .i_run_stop (i_run_stop),
    .i_clear    (i_clear),
`ifdef TICK_COUNTER_LOAD_EN
    .i_load     (i_load),
    .i_load_val (i_load_val),
`endif
    .o_count    (o_count),
    .o_running  (o_running),
    .o_tick     (o_tick),
    .o_tc       (o_tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run/clear flags, cycles spent in RUN, integer count with modulo arithmetic.
  bit m_run, m_clr, m_tick, m_tc;
  int m_age, m_count;

  always @(posedge clk or posedge reset) begin
    bit nxt_run, nxt_clr, take;
    if (reset) begin
      m_run = 0; m_clr = 0; m_tick = 0; m_tc = 0; m_age = 0; m_count = 0;
    end else begin
      if (i_clear)         begin nxt_run = 0;      nxt_clr = 1; end
      else if (m_clr)      begin nxt_run = 0;      nxt_clr = 0; end
      else if (i_run_stop) begin nxt_run = !m_run; nxt_clr = 0; end
      else                 begin nxt_run = m_run;  nxt_clr = 0; end
      take = m_tick && m_run && nxt_run;
      m_tc = 0;
      if (i_clear) m_count = 0;
`ifdef TICK_COUNTER_LOAD_EN
      else if (i_load) m_count = (int'(i_load_val) >= MOD) ? MOD - 1 : int'(i_load_val);
`endif
      else if (take) begin
        if (i_mode == 1'b0) begin
          m_tc = (m_count + 1 == MOD);
          m_count = (m_count + 1) % MOD;
        end else begin
          m_tc = (m_count == 0);
          m_count = (m_count + MOD - 1) % MOD;
        end
      end
      m_tick = m_run && ((m_age + 1) % P == 0);
      m_age  = (m_run && nxt_run) ? m_age + 1 : 0;
      m_run  = nxt_run;
      m_clr  = nxt_clr;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_count",   int'(o_count),   m_count);
      check("model_running", int'(o_running), int'(m_run));
      check("model_tick",    int'(o_tick),    int'(m_tick));
      check("model_tc",      int'(o_tc),      int'(m_tc));
    end
  end

  task automatic pulse_run();
    i_run_stop = 1'b1;
    @(negedge clk);
    i_run_stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_mode = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0;
`ifdef TICK_COUNTER_LOAD_EN
    i_load = 1'b0; i_load_val = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_count",   int'(o_count),   0);
    check("rst_running", int'(o_running), 0);
    check("rst_tick",    int'(o_tick),    0);
    check("rst_tc",      int'(o_tc),      0);

    // Up-count through one full wrap.
    pulse_run();
    check("run_up", int'(o_running), 1);
    repeat (9) @(negedge clk);
    check("no_early_tick", int'(o_tick), 0);
    @(negedge clk);
    check("first_tick", int'(o_tick), 1);
    check("count_before_tick", int'(o_count), 0);
    @(negedge clk);
    check("count_1", int'(o_count), 1);
    repeat (90) @(negedge clk);
    check("wrap_up_count", int'(o_count), 0);
    check("wrap_up_tc",    int'(o_tc),    1);

    // Reverse direction from 0.
    i_mode = 1'b1;
    repeat (10) @(negedge clk);
    check("wrap_down_count", int'(o_count), 9);
    check("wrap_down_tc",    int'(o_tc),    1);
    repeat (10) @(negedge clk);
    check("down_8", int'(o_count), 8);
    repeat (10) @(negedge clk);
    check("down_7", int'(o_count), 7);
    repeat (30) @(negedge clk);
    check("down_4", int'(o_count), 4);

    // Stop at 4, hold, restart.
    i_mode = 1'b0;
    pulse_run();
    check("stopped", int'(o_running), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_count", int'(o_count), 4);
      check("hold_notick", int'(o_tick), 0);
    end
    pulse_run();
    repeat (10) @(negedge clk);
    check("restart_tick", int'(o_tick), 1);
    @(negedge clk);
    check("restart_count", int'(o_count), 5);
    repeat (20) @(negedge clk);
    check("at_7", int'(o_count), 7);

    // Clear and run_stop together.
    i_clear = 1'b1; i_run_stop = 1'b1;
    @(negedge clk);
    i_clear = 1'b0; i_run_stop = 1'b0;
    check("clear_count",   int'(o_count),   0);
    check("clear_running", int'(o_running), 0);
    @(negedge clk);
    check("post_clear_count",   int'(o_count),   0);
    check("post_clear_running", int'(o_running), 0);

    // Stop coinciding with a tick: tick discarded.
    pulse_run();
    repeat (40) @(negedge clk);
    check("tick_at_3", int'(o_tick), 1);
    check("count_3",   int'(o_count), 3);
    pulse_run();
    check("discard_count", int'(o_count), 3);
    check("discard_tc",    int'(o_tc), 0);
    check("discard_run",   int'(o_running), 0);
    repeat (12) @(negedge clk);
    check("discard_hold", int'(o_count), 3);

`ifdef TICK_COUNTER_LOAD_EN
    i_load = 1'b1; i_load_val = W'(12);
    @(negedge clk);
    check("load_clamp", int'(o_count), 9);
    check("load_tc",    int'(o_tc), 0);
    i_load_val = W'(5); i_clear = 1'b1;
    @(negedge clk);
    check("load_vs_clear", int'(o_count), 0);
    i_load = 1'b0; i_clear = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; i_run_stop = 1'b0; i_clear = 1'b0;
`ifdef TICK_COUNTER_LOAD_EN
        i_load = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b0;
      end else begin
        i_run_stop = ($urandom_range(0, 24) == 0);
        i_clear    = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 7) == 0) i_mode = ~i_mode;
`ifdef TICK_COUNTER_LOAD_EN
        i_load     = ($urandom_range(0, 59) == 0);
        i_load_val = W'($urandom_range(0, (1 << W) - 1));
`endif
        @(negedge clk);
      end
    end
    i_run_stop = 1'b0; i_clear = 1'b0;
`ifdef TICK_COUNTER_LOAD_EN
    i_load = 1'b0;
`endif
    @(negedge clk);

    // Async reset mid-run returns outputs to reset values at once.
    pulse_run();
    repeat (25) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count",   int'(o_count),   0);
    check("async_rst_running", int'(o_running), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
